mem_stage_sb: RTL and testbench

Parametrised successor to the single-request memory stage. It performs MIPS-style loads and stores over the dbus valid/addr_ok/data_ok handshake and detects alignment exceptions (ADEL/ADES). Committed stores are retired into a SB_DEPTH-entry in-order store buffer, so the pipeline does not stall on store data_ok. The block sits between the execute/memory pipeline register and the data bus; a stall output freezes the pipeline while a load is outstanding or the buffer is full.

---
 rtl/mem_stage_sb_if.sv | 22 ++
 rtl/mem_stage_sb.sv | 250 +++++++++++++++++++++++++
 tb/tb_mem_stage_sb.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_sb_if.sv
// Data-bus bundle between mem_stage_sb (master) and the memory system (slave):
// valid/addr_ok/data_ok request-response handshake.
interface mem_stage_sb_if;
    logic        dreq_valid;
    logic [31:0] dreq_addr;
    logic [1:0]  dreq_size;
    logic [3:0]  dreq_strobe;
    logic [31:0] dreq_data;
    logic        dresp_addr_ok;
    logic        dresp_data_ok;
    logic [31:0] dresp_data;

    modport master (
        output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
        input  dresp_addr_ok, dresp_data_ok, dresp_data
    );

    modport slave (
        input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
        output dresp_addr_ok, dresp_data_ok, dresp_data
    );
endinterface

// File: rtl/mem_stage_sb.sv
// MIPS load/store memory stage with an in-order SB_DEPTH-entry store buffer.
// Define MEM_SB_FWD_EN to enable store-to-load forwarding from the buffer.
module mem_stage_sb #(
    parameter int SB_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_store,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic        req_kill,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        flush,
    output logic        stall,
    output logic [31:0] ld_data,
    output logic        exc_adel,
    output logic        exc_ades,
    output logic [31:0] badvaddr,
    output logic        sb_empty,
    mem_stage_sb_if.master dbus
);
    localparam int PTR_W = $clog2(SB_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {LD_IDLE, LD_ADDR, LD_DATA, LD_DRAIN} ld_state_t;
    typedef enum logic [1:0] {SD_IDLE, SD_ADDR, SD_DATA} sd_state_t;

    ld_state_t ld_state;
    sd_state_t sd_state;

    logic        addr_ok, data_ok;
    logic        misaligned, live, do_load, do_store, ld_go;
    logic [3:0]  req_strobe;
    logic [31:0] req_sdata;

    logic [29:0]      sb_addr   [SB_DEPTH];
    logic [3:0]       sb_strobe [SB_DEPTH];
    logic [31:0]      sb_data   [SB_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] sb_count;
    logic             sb_full, sb_push, sb_pop, st_stall;

    logic        ld_fwd, ld_issue, ld_done, ld_stall;
    logic [31:0] ld_addr_q;
    logic [1:0]  ld_size_q;
    logic        ld_signed_q;
    logic [1:0]  ld_off, ld_sz;
    logic        ld_sg;
    logic [31:0] ld_src;

    function automatic logic [31:0] load_extend(input logic [31:0] raw, input logic [1:0] off,
                                                input logic [1:0] size, input logic sgn);
        logic [31:0] sh;
        sh = raw >> {off, 3'b000};
        case (size)
            2'd0:    return {{24{sgn & sh[7]}}, sh[7:0]};
            2'd1:    return {{16{sgn & sh[15]}}, sh[15:0]};
            default: return sh;
        endcase
    endfunction

    assign addr_ok = dbus.dresp_addr_ok;
    assign data_ok = dbus.dresp_data_ok;

    // Request decode: sizes 2 and 3 both behave as word accesses.
    assign misaligned = (req_size == 2'd1 && req_addr[0]) || (req_size[1] && req_addr[1:0] != 2'b00);
    assign live       = req_valid && !req_kill;
    assign do_load    = live && !req_store && !misaligned;
    assign do_store   = live && req_store && !misaligned;
    assign exc_adel   = live && !req_store && misaligned;
    assign exc_ades   = live && req_store && misaligned;
    assign badvaddr   = (exc_adel || exc_ades) ? req_addr : 32'd0;
    assign ld_go      = do_load && !flush;

    always_comb begin
        // NOTE: default assignment first in every always_comb so no path can infer a latch.
        req_strobe = 4'b1111;
        case (req_size)
            2'd0:    req_strobe = 4'b0001 << req_addr[1:0];
            2'd1:    req_strobe = 4'b0011 << req_addr[1:0];
            default: req_strobe = 4'b1111;
        endcase
        req_sdata = req_wdata << {req_addr[1:0], 3'b000};
    end

    assign sb_full  = (sb_count == CNT_W'(SB_DEPTH));
    assign sb_pop   = (sd_state == SD_ADDR && addr_ok && data_ok) || (sd_state == SD_DATA && data_ok);
    assign sb_push  = do_store && (!sb_full || sb_pop);
    assign st_stall = do_store && sb_full && !sb_pop;
    assign sb_empty = (sb_count == '0) && (sd_state == SD_IDLE);

`ifdef MEM_SB_FWD_EN
    logic             fwd_hit, fwd_full;
    logic [PTR_W-1:0] fwd_idx;
    logic [31:0]      fwd_data;

    // Scan oldest to youngest so the last match found is the youngest store.
    always_comb begin
        logic [PTR_W-1:0] idx;
        fwd_hit = 1'b0;
        fwd_idx = rd_ptr;
        idx     = rd_ptr;
        for (int i = 0; i < SB_DEPTH; i++) begin
            idx = rd_ptr + PTR_W'(i);
            if (CNT_W'(i) < sb_count && sb_addr[idx] == req_addr[31:2]) begin
                fwd_hit = 1'b1;
                fwd_idx = idx;
            end
        end
        fwd_full = (sb_strobe[fwd_idx] & req_strobe) == req_strobe;
        fwd_data = sb_data[fwd_idx];
    end
`endif

    always_comb begin
        ld_fwd   = 1'b0;
        ld_issue = 1'b0;
        ld_done  = 1'b0;
        ld_stall = 1'b0;
        case (ld_state)
            LD_IDLE: begin
`ifdef MEM_SB_FWD_EN
                ld_fwd   = ld_go && fwd_hit && fwd_full;
                ld_issue = ld_go && !fwd_hit && (sd_state == SD_IDLE);
`else
                ld_issue = ld_go && (sb_count == '0) && (sd_state == SD_IDLE);
`endif
                ld_done  = ld_fwd || (ld_issue && addr_ok && data_ok);
                ld_stall = ld_go && !ld_done;
            end
            LD_ADDR: begin
                ld_done  = addr_ok && data_ok && !flush;
                ld_stall = !(addr_ok && data_ok) && !flush;
            end
            LD_DATA: begin
                ld_done  = data_ok && !flush;
                ld_stall = !data_ok && !flush;
            end
            default: ld_stall = ld_go;
        endcase
    end

    assign stall = st_stall || ld_stall;

    always_comb begin
        ld_off = ld_addr_q[1:0];
        ld_sz  = ld_size_q;
        ld_sg  = ld_signed_q;
        if (ld_state == LD_IDLE) begin
            ld_off = req_addr[1:0];
            ld_sz  = req_size;
            ld_sg  = req_signed;
        end
        ld_src = dbus.dresp_data;
`ifdef MEM_SB_FWD_EN
        if (ld_fwd) ld_src = fwd_data;
`endif
        ld_data = ld_done ? load_extend(ld_src, ld_off, ld_sz, ld_sg) : 32'd0;
    end

    // Bus owner: a freshly issued load, a held load, or the buffer head.
    always_comb begin
        dbus.dreq_valid  = 1'b0;
        dbus.dreq_addr   = 32'd0;
        dbus.dreq_size   = 2'd0;
        dbus.dreq_strobe = 4'b0000;
        dbus.dreq_data   = 32'd0;
        if (ld_issue) begin
            dbus.dreq_valid = 1'b1;
            dbus.dreq_addr  = req_addr;
            dbus.dreq_size  = req_size;
        end else if (ld_state == LD_ADDR) begin
            dbus.dreq_valid = !flush;
            dbus.dreq_addr  = ld_addr_q;
            dbus.dreq_size  = ld_size_q;
        end else if (sd_state == SD_ADDR) begin
            dbus.dreq_valid  = 1'b1;
            dbus.dreq_addr   = {sb_addr[rd_ptr], 2'b00};
            dbus.dreq_size   = 2'd2;
            dbus.dreq_strobe = sb_strobe[rd_ptr];
            dbus.dreq_data   = sb_data[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            ld_state    <= LD_IDLE;
            ld_addr_q   <= 32'd0;
            ld_size_q   <= 2'd0;
            ld_signed_q <= 1'b0;
        end else begin
            case (ld_state)
                LD_IDLE: if (ld_issue) begin
                    ld_addr_q   <= req_addr;
                    ld_size_q   <= req_size;
                    ld_signed_q <= req_signed;
                    if (!addr_ok)      ld_state <= LD_ADDR;
                    else if (!data_ok) ld_state <= LD_DATA;
                end
                LD_ADDR: begin
                    if (flush)        ld_state <= LD_IDLE;
                    else if (addr_ok) ld_state <= data_ok ? LD_IDLE : LD_DATA;
                end
                LD_DATA: begin
                    if (data_ok)    ld_state <= LD_IDLE;
                    else if (flush) ld_state <= LD_DRAIN;
                end
                default: if (data_ok) ld_state <= LD_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sd_state <= SD_IDLE;
        end else begin
            case (sd_state)
                SD_IDLE: if ((sb_count != '0 || sb_push) && ld_state == LD_IDLE && !ld_issue)
                    sd_state <= SD_ADDR;
                SD_ADDR: if (addr_ok) sd_state <= data_ok ? SD_IDLE : SD_DATA;
                SD_DATA: if (data_ok) sd_state <= SD_IDLE;
                default: sd_state <= SD_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            sb_count <= '0;
        end else begin
            if (sb_push) wr_ptr <= wr_ptr + 1'b1;
            if (sb_pop)  rd_ptr <= rd_ptr + 1'b1;
            sb_count <= sb_count + CNT_W'(sb_push) - CNT_W'(sb_pop);
        end
    end

    // NOTE: buffer storage is not reset; entries are only read once the count covers them.
    always_ff @(posedge clk) begin
        if (sb_push) begin
            sb_addr[wr_ptr]   <= req_addr[31:2];
            sb_strobe[wr_ptr] <= req_strobe;
            sb_data[wr_ptr]   <= req_sdata;
        end
    end
endmodule

// File: tb/tb_mem_stage_sb.sv
// Directed self-checking bench for mem_stage_sb (SB_DEPTH = 4); bus responses
// are driven per cycle by each scenario task.
module tb_mem_stage_sb;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_store, req_signed, req_kill, flush;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        stall, exc_adel, exc_ades, sb_empty;
    logic [31:0] ld_data, badvaddr;
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_stage_sb_if dbus ();

    mem_stage_sb #(.SB_DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_store(req_store), .req_size(req_size),
        .req_signed(req_signed), .req_kill(req_kill), .req_addr(req_addr),
        .req_wdata(req_wdata), .flush(flush), .stall(stall), .ld_data(ld_data),
        .exc_adel(exc_adel), .exc_ades(exc_ades), .badvaddr(badvaddr),
        .sb_empty(sb_empty), .dbus(dbus)
    );

    task automatic drive(input logic v, input logic st, input logic [1:0] sz, input logic sg,
                         input logic kill, input logic [31:0] a, input logic [31:0] wd);
        req_valid = v; req_store = st; req_size = sz; req_signed = sg;
        req_kill = kill; req_addr = a; req_wdata = wd;
    endtask

    task automatic bus(input logic aok, input logic dok, input logic [31:0] d);
        dbus.dresp_addr_ok = aok; dbus.dresp_data_ok = dok; dbus.dresp_data = d;
    endtask

    task automatic quiet();
        drive(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        bus(1'b0, 1'b0, 32'd0);
        flush = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        quiet();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_stall: got %b want 0", stall); end
        total++; if (sb_empty !== 1'b1) begin bad++; $display("FAIL rst_sb_empty: got %b want 1", sb_empty); end
        total++; if (dbus.dreq_valid !== 1'b0) begin bad++; $display("FAIL rst_dreq_valid: got %b want 0", dbus.dreq_valid); end
        total++; if ({exc_adel, exc_ades, ld_data, badvaddr} !== 66'd0) begin bad++;
            $display("FAIL rst_outputs: got adel=%b ades=%b ld=%h bva=%h want all 0", exc_adel, exc_ades, ld_data, badvaddr); end
    endtask

    task automatic test_load_fast();
        logic [1:0]  sz [4]  = '{2'd2, 2'd1, 2'd0, 2'd0};
        logic        sg [4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] ad [4]  = '{32'h100, 32'h102, 32'h103, 32'h101};
        logic [31:0] rd [4]  = '{32'hDEADBEEF, 32'h8001_0000, 32'hAB00_0000, 32'h0000_8000};
        logic [31:0] ex [4]  = '{32'hDEADBEEF, 32'hFFFF8001, 32'h0000_00AB, 32'hFFFF_FF80};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, sz[i], sg[i], 1'b0, ad[i], 32'd0);
            bus(1'b1, 1'b1, rd[i]);
            #1;
            total++; if (ld_data !== ex[i]) begin bad++; $display("FAIL ld_fast_data[%0d]: got %h want %h", i, ld_data, ex[i]); end
            total++; if (stall !== 1'b0) begin bad++; $display("FAIL ld_fast_stall[%0d]: got %b want 0", i, stall); end
            total++; if ({dbus.dreq_valid, dbus.dreq_addr, dbus.dreq_strobe} !== {1'b1, ad[i], 4'b0000}) begin bad++;
                $display("FAIL ld_fast_bus[%0d]: got v=%b a=%h s=%b want v=1 a=%h s=0000", i, dbus.dreq_valid, dbus.dreq_addr, dbus.dreq_strobe, ad[i]); end
        end
        @(negedge clk); quiet();
    endtask

    task automatic test_load_wait();
        @(negedge clk);
        drive(1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 32'h108, 32'd0);
        bus(1'b0, 1'b0, 32'd0);
        #1;
        total++; if ({stall, dbus.dreq_valid} !== 2'b11) begin bad++; $display("FAIL ldw_issue: got stall=%b v=%b want 1 1", stall, dbus.dreq_valid); end
        @(negedge clk);
        bus(1'b1, 1'b0, 32'd0);
        #1;
        total++; if ({stall, dbus.dreq_valid, dbus.dreq_addr} !== {2'b11, 32'h108}) begin bad++;
            $display("FAIL ldw_hold: got stall=%b v=%b a=%h want 1 1 108", stall, dbus.dreq_valid, dbus.dreq_addr); end
        @(negedge clk);
        bus(1'b0, 1'b0, 32'd0);
        #1;
        total++; if ({stall, dbus.dreq_valid} !== 2'b10) begin bad++; $display("FAIL ldw_data_wait: got stall=%b v=%b want 1 0", stall, dbus.dreq_valid); end
        @(negedge clk);
        bus(1'b0, 1'b1, 32'h12345678);
        #1;
        total++; if ({stall, ld_data} !== {1'b0, 32'h12345678}) begin bad++; $display("FAIL ldw_done: got stall=%b ld=%h want 0 12345678", stall, ld_data); end
        @(negedge clk); quiet();
    endtask

    task automatic test_align();
        @(negedge clk);
        drive(1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 32'h201, 32'hCAFE);
        #1;
        total++; if ({exc_ades, exc_adel, badvaddr} !== {2'b10, 32'h201}) begin bad++;
            $display("FAIL sw_ades: got ades=%b adel=%b bva=%h want 1 0 201", exc_ades, exc_adel, badvaddr); end
        total++; if ({dbus.dreq_valid, stall} !== 2'b00) begin bad++; $display("FAIL sw_ades_noacc: got v=%b stall=%b want 0 0", dbus.dreq_valid, stall); end
        @(negedge clk);
        drive(1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 32'h203, 32'd0);
        #1;
        total++; if ({exc_ades, exc_adel, badvaddr, dbus.dreq_valid} !== {2'b01, 32'h203, 1'b0}) begin bad++;
            $display("FAIL lh_adel: got ades=%b adel=%b bva=%h v=%b want 0 1 203 0", exc_ades, exc_adel, badvaddr, dbus.dreq_valid); end
        @(negedge clk);
        drive(1'b1, 1'b1, 2'd2, 1'b0, 1'b1, 32'h201, 32'hCAFE);
        #1;
        total++; if ({exc_ades, exc_adel, badvaddr, dbus.dreq_valid} !== 35'd0) begin bad++;
            $display("FAIL sw_kill: got ades=%b adel=%b bva=%h v=%b want all 0", exc_ades, exc_adel, badvaddr, dbus.dreq_valid); end
        @(negedge clk); quiet();
        #1;
        total++; if ({sb_empty, dbus.dreq_valid} !== 2'b10) begin bad++; $display("FAIL align_no_push: got empty=%b v=%b want 1 0", sb_empty, dbus.dreq_valid); end
    endtask

    task automatic test_sb_full();
        int seen = 0;
        logic [3:0]  es;
        logic [31:0] ed, ea;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 32'h400 + i, 32'h11 * (i + 1));
            bus(1'b0, 1'b0, 32'd0);
            #1;
            total++; if (stall !== (i == 4)) begin bad++; $display("FAIL sb_fill_stall[%0d]: got %b want %b", i, stall, i == 4); end
            if (i == 1) begin
                total++; if ({dbus.dreq_valid, dbus.dreq_strobe, dbus.dreq_addr} !== {1'b1, 4'b0001, 32'h400}) begin bad++;
                    $display("FAIL sb_first_req: got v=%b s=%b a=%h want 1 0001 400", dbus.dreq_valid, dbus.dreq_strobe, dbus.dreq_addr); end
            end
        end
        @(negedge clk);
        bus(1'b1, 1'b1, 32'd0);
        #1;
        total++; if ({stall, dbus.dreq_strobe, dbus.dreq_data} !== {1'b0, 4'b0001, 32'h11}) begin bad++;
            $display("FAIL sb_release: got stall=%b s=%b d=%h want 0 0001 11", stall, dbus.dreq_strobe, dbus.dreq_data); end
        @(negedge clk);
        drive(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        for (int cyc = 0; cyc < 40 && seen < 4; cyc++) begin
            if (cyc != 0) @(negedge clk);
            #1;
            if (dbus.dreq_valid) begin
                case (seen)
                    0:       begin es = 4'b0010; ed = 32'h0000_2200; ea = 32'h400; end
                    1:       begin es = 4'b0100; ed = 32'h0033_0000; ea = 32'h400; end
                    2:       begin es = 4'b1000; ed = 32'h4400_0000; ea = 32'h400; end
                    default: begin es = 4'b0001; ed = 32'h0000_0055; ea = 32'h404; end
                endcase
                total++; if ({dbus.dreq_strobe, dbus.dreq_data, dbus.dreq_addr} !== {es, ed, ea}) begin bad++;
                    $display("FAIL sb_drain[%0d]: got s=%b d=%h a=%h want s=%b d=%h a=%h", seen, dbus.dreq_strobe, dbus.dreq_data, dbus.dreq_addr, es, ed, ea); end
                seen++;
            end
        end
        total++; if (seen !== 4) begin bad++; $display("FAIL sb_drain_timeout: got %0d entries want 4", seen); end
        @(negedge clk); quiet();
        #1;
        total++; if (sb_empty !== 1'b1) begin bad++; $display("FAIL sb_drained_empty: got %b want 1", sb_empty); end
    endtask

    task automatic test_store_load();
        @(negedge clk);
        drive(1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 32'h300, 32'h11223344);
        bus(1'b0, 1'b0, 32'd0);
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL sl_store_stall: got %b want 0", stall); end
        @(negedge clk);
        drive(1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 32'h300, 32'd0);
`ifdef MEM_SB_FWD_EN
        #1;
        total++; if ({stall, ld_data} !== {1'b0, 32'h11223344}) begin bad++; $display("FAIL fwd_data: got stall=%b ld=%h want 0 11223344", stall, ld_data); end
        total++; if (dbus.dreq_strobe !== 4'b1111) begin bad++; $display("FAIL fwd_no_read: got strobe=%b want 1111 (store drain only)", dbus.dreq_strobe); end
        @(negedge clk);
        drive(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        bus(1'b1, 1'b1, 32'd0);
`else
        bus(1'b1, 1'b0, 32'd0);
        #1;
        total++; if ({stall, dbus.dreq_strobe} !== {1'b1, 4'b1111}) begin bad++; $display("FAIL sl_wait_store: got stall=%b s=%b want 1 1111", stall, dbus.dreq_strobe); end
        @(negedge clk);
        bus(1'b0, 1'b0, 32'd0);
        #1;
        total++; if ({stall, dbus.dreq_valid} !== 2'b10) begin bad++; $display("FAIL sl_wait_data: got stall=%b v=%b want 1 0", stall, dbus.dreq_valid); end
        @(negedge clk);
        bus(1'b0, 1'b1, 32'd0);
        #1;
        total++; if ({stall, dbus.dreq_valid} !== 2'b10) begin bad++; $display("FAIL sl_pop_cycle: got stall=%b v=%b want 1 0", stall, dbus.dreq_valid); end
        @(negedge clk);
        bus(1'b1, 1'b1, 32'h11223344);
        #1;
        total++; if ({stall, ld_data, dbus.dreq_strobe, dbus.dreq_addr} !== {1'b0, 32'h11223344, 4'b0000, 32'h300}) begin bad++;
            $display("FAIL sl_load: got stall=%b ld=%h s=%b a=%h want 0 11223344 0000 300", stall, ld_data, dbus.dreq_strobe, dbus.dreq_addr); end
`endif
        @(negedge clk); quiet();
        #1;
        total++; if (sb_empty !== 1'b1) begin bad++; $display("FAIL sl_empty: got %b want 1", sb_empty); end
    endtask

    task automatic test_flush();
        @(negedge clk);
        drive(1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 32'h500, 32'd0);
        bus(1'b1, 1'b0, 32'd0);
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL fl_issue_stall: got %b want 1", stall); end
        @(negedge clk);
        drive(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        bus(1'b0, 1'b0, 32'd0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        drive(1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 32'h504, 32'd0);
        bus(1'b0, 1'b1, 32'hBAD0BAD0);
        #1;
        total++; if ({stall, ld_data, dbus.dreq_valid} !== {1'b1, 32'd0, 1'b0}) begin bad++;
            $display("FAIL fl_discard: got stall=%b ld=%h v=%b want 1 0 0", stall, ld_data, dbus.dreq_valid); end
        @(negedge clk);
        bus(1'b1, 1'b1, 32'hC0FFEE00);
        #1;
        total++; if ({stall, ld_data, dbus.dreq_addr} !== {1'b0, 32'hC0FFEE00, 32'h504}) begin bad++;
            $display("FAIL fl_next_load: got stall=%b ld=%h a=%h want 0 c0ffee00 504", stall, ld_data, dbus.dreq_addr); end
        // Flush while the address phase is still pending drops the request.
        @(negedge clk);
        drive(1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 32'h600, 32'd0);
        bus(1'b0, 1'b0, 32'd0);
        @(negedge clk);
        drive(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        flush = 1'b1;
        #1;
        total++; if (dbus.dreq_valid !== 1'b0) begin bad++; $display("FAIL fl_addr_drop: got v=%b want 0", dbus.dreq_valid); end
        @(negedge clk);
        flush = 1'b0;
        drive(1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 32'h606, 32'd0);
        bus(1'b1, 1'b1, 32'hBEEF_0000);
        #1;
        total++; if ({stall, ld_data} !== {1'b0, 32'h0000_BEEF}) begin bad++; $display("FAIL fl_addr_next: got stall=%b ld=%h want 0 0000beef", stall, ld_data); end
        @(negedge clk); quiet();
    endtask

    initial begin
        test_reset();
        test_load_fast();
        test_load_wait();
        test_align();
        test_sb_full();
        test_store_load();
        test_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
